// File: rtl/mesh_term_chkr.sv
// rtl/mesh_term_chkr.sv - mesh_gnrtr exit-terminal checker with round-robin event port
// Optional: define MESH_CHK_TSTAMP_EN to add a 32-bit capture timestamp output (evt_ts).
module mesh_term_chkr #(
    parameter int         ROWS    = 4,
    parameter int         COLUMS  = 4,
    parameter int         PCKG_SZ = 40,
    parameter logic [7:0] BDCST   = 8'hFF,
    parameter int         CNT_W   = 16,
    parameter int         NTERM   = 2*ROWS + 2*COLUMS,
    localparam int        TW      = $clog2(NTERM)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NTERM-1:0]         pndng,
    input  logic [NTERM*PCKG_SZ-1:0] data_out,
    output logic [NTERM-1:0]         pop,
    input  logic                     clr,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TW-1:0]            evt_term,
    output logic [PCKG_SZ-1:0]       evt_data,
    output logic                     evt_bad,
    input  logic [TW-1:0]            cnt_sel,
    output logic [CNT_W-1:0]         cnt_good,
    output logic [CNT_W-1:0]         cnt_bad,
`ifdef MESH_CHK_TSTAMP_EN
    output logic [31:0]              evt_ts,
`endif
    output logic                     bad_any
);

    // Terminal ring: top edge, left edge, bottom edge, right edge.
    function automatic logic [3:0] coord_row(input int id);
        if (id < COLUMS)               return 4'd0;
        else if (id < COLUMS+ROWS)     return 4'(id - COLUMS + 1);
        else if (id < 2*COLUMS+ROWS)   return 4'(ROWS + 1);
        else                           return 4'(id - 2*COLUMS - ROWS + 1);
    endfunction

    function automatic logic [3:0] coord_col(input int id);
        if (id < COLUMS)               return 4'(id + 1);
        else if (id < COLUMS+ROWS)     return 4'd0;
        else if (id < 2*COLUMS+ROWS)   return 4'(id - COLUMS - ROWS + 1);
        else                           return 4'(COLUMS + 1);
    endfunction

    logic [PCKG_SZ-1:0] w_word [NTERM];
    logic [NTERM-1:0]   w_bad_in;
    logic [NTERM-1:0]   w_pop;
    logic [NTERM-1:0]   w_drain;
    logic [NTERM-1:0]   r_hold_vld;
    logic [NTERM-1:0]   r_hold_bad;
    logic [PCKG_SZ-1:0] r_hold_data [NTERM];
    logic [CNT_W-1:0]   r_cnt_good [NTERM];
    logic [CNT_W-1:0]   r_cnt_bad [NTERM];
    logic [CNT_W-1:0]   r_cnt_good_q;
    logic [CNT_W-1:0]   r_cnt_bad_q;
    logic [TW-1:0]      r_ptr;
    logic [TW-1:0]      r_lock_gnt;
    logic [TW-1:0]      w_srch;
    logic [TW-1:0]      w_gnt;
    logic               r_locked;
    logic               r_bad_any;
    logic               w_evt_valid;
    logic               w_accept;
    logic               w_found;
    logic               w_sel_ok;
    int                 w_idx;

    always_comb begin
        for (int i = 0; i < NTERM; i++) begin
            w_word[i]   = data_out[i*PCKG_SZ +: PCKG_SZ];
            w_bad_in[i] = (w_word[i][PCKG_SZ-1 -: 8] != BDCST) &&
                          ((w_word[i][PCKG_SZ-9 -: 4] != coord_row(i)) ||
                           (w_word[i][PCKG_SZ-13 -: 4] != coord_col(i)));
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_srch  = r_ptr;
        w_idx   = 0;
        for (int k = 0; k < NTERM; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NTERM) w_idx = w_idx - NTERM;
            if (!w_found && r_hold_vld[w_idx]) begin
                w_found = 1'b1;
                w_srch  = TW'(w_idx);
            end
        end
        // A stalled grant stays put so the consumer sees stable outputs.
        w_gnt = r_locked ? r_lock_gnt : w_srch;
    end

    assign w_evt_valid = (|r_hold_vld) & ~reset;
    assign w_accept    = w_evt_valid & evt_ready;
    assign w_drain     = (NTERM'(1) << w_gnt) & {NTERM{w_accept}};
    assign w_pop       = pndng & {NTERM{~reset}} & (~r_hold_vld | w_drain);
    assign w_sel_ok    = ({1'b0, cnt_sel} < (TW+1)'(NTERM));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_vld   <= '0;
            r_ptr        <= '0;
            r_locked     <= 1'b0;
            r_lock_gnt   <= '0;
            r_bad_any    <= 1'b0;
            r_cnt_good_q <= '0;
            r_cnt_bad_q  <= '0;
            for (int i = 0; i < NTERM; i++) begin
                r_cnt_good[i] <= '0;
                r_cnt_bad[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NTERM; i++) begin
                if (w_pop[i]) begin
                    r_hold_vld[i]  <= 1'b1;
                    r_hold_data[i] <= w_word[i];
                    r_hold_bad[i]  <= w_bad_in[i];
                end else if (w_drain[i]) begin
                    r_hold_vld[i]  <= 1'b0;
                end
                // clr wins over a same-cycle capture: the word is held but not counted.
                if (clr) begin
                    r_cnt_good[i] <= '0;
                    r_cnt_bad[i]  <= '0;
                end else if (w_pop[i]) begin
                    if (w_bad_in[i]) begin
                        if (r_cnt_bad[i] != '1) r_cnt_bad[i] <= r_cnt_bad[i] + CNT_W'(1);
                    end else begin
                        if (r_cnt_good[i] != '1) r_cnt_good[i] <= r_cnt_good[i] + CNT_W'(1);
                    end
                end
            end
            if (clr)
                r_bad_any <= 1'b0;
            else if (|(w_pop & w_bad_in))
                r_bad_any <= 1'b1;
            if (w_accept)
                r_ptr <= (w_gnt == TW'(NTERM-1)) ? '0 : w_gnt + TW'(1);
            r_locked     <= w_evt_valid & ~evt_ready;
            r_lock_gnt   <= w_gnt;
            r_cnt_good_q <= w_sel_ok ? r_cnt_good[cnt_sel] : '0;
            r_cnt_bad_q  <= w_sel_ok ? r_cnt_bad[cnt_sel]  : '0;
        end
    end

`ifdef MESH_CHK_TSTAMP_EN
    logic [31:0] r_ts;
    logic [31:0] r_hold_ts [NTERM];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
            for (int i = 0; i < NTERM; i++)
                if (w_pop[i]) r_hold_ts[i] <= r_ts;
        end
    end

    assign evt_ts = r_hold_ts[w_gnt];
`endif

    assign pop       = w_pop;
    assign evt_valid = w_evt_valid;
    assign evt_term  = w_gnt;
    assign evt_data  = r_hold_data[w_gnt];
    assign evt_bad   = r_hold_bad[w_gnt];
    assign cnt_good  = r_cnt_good_q;
    assign cnt_bad   = r_cnt_bad_q;
    assign bad_any   = r_bad_any;

endmodule

// File: tb/tb_mesh_term_chkr.sv
// tb/tb_mesh_term_chkr.sv - self-checking bench for mesh_term_chkr (4x4 mesh, CNT_W 16 and 2)
module tb_mesh_term_chkr;
    localparam int R = 4, C = 4, PW = 40, N = 16, TW = 4;

    logic            clk = 1'b0;
    logic            reset, clr, evt_ready;
    logic [N-1:0]    pndng;
    logic [N*PW-1:0] data_out;
    logic [TW-1:0]   cnt_sel;
    logic [N-1:0]    pop, pop_s;
    logic            evt_valid, evt_bad, bad_any, evt_valid_s, evt_bad_s, bad_any_s;
    logic [TW-1:0]   evt_term, evt_term_s;
    logic [PW-1:0]   evt_data, evt_data_s;
    logic [15:0]     cnt_good, cnt_bad;
    logic [1:0]      cnt_good_s, cnt_bad_s;
`ifdef MESH_CHK_TSTAMP_EN
    logic [31:0]     evt_ts, evt_ts_s;
`endif

    always #5 clk = ~clk;

    mesh_term_chkr #(.ROWS(R), .COLUMS(C), .PCKG_SZ(PW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop), .clr(clr),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_term(evt_term), .evt_data(evt_data),
        .evt_bad(evt_bad), .cnt_sel(cnt_sel), .cnt_good(cnt_good), .cnt_bad(cnt_bad),
`ifdef MESH_CHK_TSTAMP_EN
        .evt_ts(evt_ts),
`endif
        .bad_any(bad_any));

    mesh_term_chkr #(.ROWS(R), .COLUMS(C), .PCKG_SZ(PW), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop_s), .clr(clr),
        .evt_valid(evt_valid_s), .evt_ready(evt_ready), .evt_term(evt_term_s), .evt_data(evt_data_s),
        .evt_bad(evt_bad_s), .cnt_sel(cnt_sel), .cnt_good(cnt_good_s), .cnt_bad(cnt_bad_s),
`ifdef MESH_CHK_TSTAMP_EN
        .evt_ts(evt_ts_s),
`endif
        .bad_any(bad_any_s));

    // Reference model: source FIFOs, one outstanding capture per terminal, plain counts.
    logic [PW-1:0] src_q [N][$];
    bit            m_held [N];
    logic [PW-1:0] m_data [N];
    logic [31:0]   m_ts [N];
    int            m_cg [N], m_cb [N];
    int            m_ptr, m_lock_t, m_rd_g, m_rd_b;
    bit            m_locked, m_bad_any;
    logic [31:0]   m_cyc;
    int            acc_log [$];
    bit            acc_seen, acc_bad;
    int            errors = 0, checks = 0;

    typedef struct { int term; logic [7:0] nx; logic [3:0] row; logic [3:0] col; bit bad; } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void coords(input int t, output int er, output int ec);
        if (t < C)            begin er = 0;           ec = t + 1;         end
        else if (t < C+R)     begin er = t - C + 1;   ec = 0;             end
        else if (t < 2*C+R)   begin er = R + 1;       ec = t - C - R + 1; end
        else                  begin er = t-2*C-R+1;   ec = C + 1;         end
    endfunction

    function automatic bit is_bad(input int t, input logic [PW-1:0] p);
        int er, ec;
        coords(t, er, ec);
        return (p[39:32] != 8'hFF) && ((int'(p[31:28]) != er) || (int'(p[27:24]) != ec));
    endfunction

    function automatic logic [PW-1:0] mkpkt(input int t, input int kind);
        int er, ec;
        logic [7:0] nx;
        logic [3:0] r, c;
        coords(t, er, ec);
        nx = 8'($urandom % 255);
        r  = 4'(er);
        c  = 4'(ec);
        if (kind == 0) nx = 8'hFF;
        if (kind <= 1) begin r = 4'($urandom); c = 4'($urandom); end
        return {nx, r, c, 1'($urandom), 23'($urandom)};
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (src_q[i].size() > 0);
            data_out[i*PW +: PW] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    endtask

    task automatic step();
        int g, idx;
        bit v, dr;
        logic [N-1:0] epop;
        @(negedge clk);
        v = 0;
        for (int i = 0; i < N; i++) if (m_held[i]) v = 1;
        v = v && !reset;
        g = -1;
        if (m_locked) g = m_lock_t;
        else for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && m_held[idx]) g = idx;
        end
        dr = v && evt_ready;
        for (int i = 0; i < N; i++)
            epop[i] = pndng[i] && !reset && (!m_held[i] || (dr && g == i));
        chk("pop", pop, epop);
        chk("evt_valid", evt_valid, v);
        if (v) begin
            chk("evt_term", evt_term, g);
            chk("evt_data", evt_data, m_data[g]);
            chk("evt_bad", evt_bad, is_bad(g, m_data[g]));
`ifdef MESH_CHK_TSTAMP_EN
            chk("evt_ts", evt_ts, m_ts[g]);
`endif
        end
        chk("cnt_good", cnt_good, sat(m_rd_g, 65535));
        chk("cnt_bad", cnt_bad, sat(m_rd_b, 65535));
        chk("cnt_good_w2", cnt_good_s, sat(m_rd_g, 3));
        chk("cnt_bad_w2", cnt_bad_s, sat(m_rd_b, 3));
        chk("bad_any", bad_any, m_bad_any);
        if (evt_valid && evt_ready) begin
            acc_seen = 1;
            acc_bad  = evt_bad;
            acc_log.push_back(int'(evt_term));
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) begin m_held[i] = 0; m_cg[i] = 0; m_cb[i] = 0; end
            m_ptr = 0; m_locked = 0; m_bad_any = 0; m_rd_g = 0; m_rd_b = 0; m_cyc = 0;
        end else begin
            m_rd_g = (cnt_sel < N) ? m_cg[cnt_sel] : 0;
            m_rd_b = (cnt_sel < N) ? m_cb[cnt_sel] : 0;
            if (dr) begin m_held[g] = 0; m_ptr = (g + 1) % N; end
            m_locked = v && !evt_ready;
            m_lock_t = g;
            for (int i = 0; i < N; i++) if (epop[i]) begin
                m_data[i] = src_q[i].pop_front();
                m_held[i] = 1;
                m_ts[i]   = m_cyc;
                if (!clr) begin
                    if (is_bad(i, m_data[i])) begin m_cb[i]++; m_bad_any = 1; end
                    else m_cg[i]++;
                end
            end
            if (clr) begin
                for (int i = 0; i < N; i++) begin m_cg[i] = 0; m_cb[i] = 0; end
                m_bad_any = 0;
            end
            m_cyc++;
        end
        #1;
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int er, ec, mism, left;
        tbl[0] = '{0,  8'h00, 4'd0, 4'd1, 1'b0};
        tbl[1] = '{4,  8'h00, 4'd2, 4'd0, 1'b1};
        tbl[2] = '{4,  8'hFF, 4'd2, 4'd0, 1'b0};
        tbl[3] = '{8,  8'h12, 4'd5, 4'd1, 1'b0};
        tbl[4] = '{11, 8'h00, 4'd5, 4'd3, 1'b1};
        tbl[5] = '{12, 8'h00, 4'd1, 4'd5, 1'b0};
        tbl[6] = '{15, 8'h00, 4'd4, 4'd5, 1'b0};
        tbl[7] = '{15, 8'h00, 4'd4, 4'd4, 1'b1};
        tbl[8] = '{3,  8'h00, 4'd0, 4'd4, 1'b0};
        tbl[9] = '{7,  8'hFE, 4'd9, 4'd9, 1'b1};

        reset = 1; clr = 0; evt_ready = 0; cnt_sel = 0;
        refresh();
        m_ptr = 0; m_locked = 0; m_bad_any = 0; m_rd_g = 0; m_rd_b = 0; m_cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        steps(1);
        reset = 0;

        // Single good packet on terminal 0.
        evt_ready = 1;
        src_q[0].push_back({8'h00, 4'd0, 4'd1, 1'b1, 23'h1});
        refresh(); #1;
        chk("t1_pop0", pop[0], 1);
        step(); #1;
        chk("t1_valid", evt_valid, 1);
        chk("t1_term", evt_term, 0);
        chk("t1_bad", evt_bad, 0);
        step(); #1;
        chk("t1_cnt_good", cnt_good, 1);

        // Classification vectors.
        for (int v = 0; v < 10; v++) begin
            src_q[tbl[v].term].push_back({tbl[v].nx, tbl[v].row, tbl[v].col, 1'b0, 23'($urandom)});
            refresh();
            acc_seen = 0;
            left = 20;
            while (!acc_seen && left > 0) begin step(); left--; end
            chk("tbl_timeout", acc_seen, 1);
            chk("tbl_bad", acc_bad, tbl[v].bad);
            chk("tbl_term", acc_log[$], tbl[v].term);
        end
        cnt_sel = 4;
        steps(2); #1;
        chk("t2_cnt_bad4", cnt_bad, 1);
        chk("t2_bad_any", bad_any, 1);

        // Stall with terminals 3 and 9 pending, then release.
        reset = 1; step(); reset = 0;
        evt_ready = 0;
        for (int k = 0; k < 2; k++) begin
            src_q[3].push_back(mkpkt(3, 2));
            src_q[9].push_back(mkpkt(9, 2));
        end
        refresh();
        steps(4); #1;
        chk("t3_term_locked", evt_term, 3);
        chk("t3_no_pop", pop, 0);
        acc_log.delete();
        evt_ready = 1;
        steps(5);
        chk("t3_acc_cnt", acc_log.size(), 4);
        if (acc_log.size() == 4) begin
            chk("t3_order0", acc_log[0], 3);
            chk("t3_order1", acc_log[1], 9);
            chk("t3_order2", acc_log[2], 3);
            chk("t3_order3", acc_log[3], 9);
        end

        // All terminals saturated with traffic: strict round-robin.
        reset = 1; step(); reset = 0;
        acc_log.delete();
        for (int t = 0; t < N; t++)
            for (int k = 0; k < 20; k++) src_q[t].push_back(mkpkt(t, $urandom % 4));
        refresh();
        steps(330);
        chk("t4_acc_cnt", acc_log.size(), 320);
        mism = 0;
        foreach (acc_log[k]) if (acc_log[k] != k % N) mism++;
        chk("t4_rr_order", mism, 0);

        // Saturation on the 2-bit instance, then clr racing a capture.
        reset = 1; step(); reset = 0;
        cnt_sel = 6;
        for (int k = 0; k < 5; k++) src_q[6].push_back(mkpkt(6, 2));
        refresh();
        steps(8); #1;
        chk("t5_sat_w2", cnt_good_s, 3);
        chk("t5_cnt_w16", cnt_good, 5);
        src_q[6].push_back(mkpkt(6, 2));
        refresh();
        clr = 1; acc_seen = 0;
        step();
        clr = 0;
        steps(3); #1;
        chk("t5_clr_cnt", cnt_good, 0);
        chk("t5_clr_cnt_w2", cnt_good_s, 0);
        chk("t5_clr_evt", acc_seen, 1);

        // Reset during a stall discards the held word and restarts the pointer.
        evt_ready = 0;
        src_q[5].push_back(mkpkt(5, 1));
        refresh();
        steps(3);
        reset = 1; step(); reset = 0; #1;
        chk("t6_valid", evt_valid, 0);
        chk("t6_bad_any", bad_any, 0);
        chk("t6_cnt", cnt_good, 0);
        src_q[14].push_back(mkpkt(14, 2));
        src_q[1].push_back(mkpkt(1, 2));
        refresh();
        steps(2); #1;
        chk("t6_ptr0", evt_term, 1);
        evt_ready = 1;
        steps(3);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int t = 0; t < N; t++)
                if ($urandom % 6 == 0 && src_q[t].size() < 4) src_q[t].push_back(mkpkt(t, $urandom % 4));
            evt_ready = ($urandom % 4) != 0;
            clr       = ($urandom % 64) == 0;
            cnt_sel   = 4'($urandom);
            reset     = ($urandom % 400) == 0;
            refresh();
            step();
        end
        reset = 0; clr = 0; evt_ready = 1;
        steps(80);
        left = 0;
        for (int t = 0; t < N; t++) left += src_q[t].size();
        chk("drained", left, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
